// File: rtl/chirp_phase_acc_if.sv
// Output sample stream of the chirp phase accumulator toward the phase-to-amplitude stage.
interface chirp_phase_acc_if #(
   parameter int WIDTH = 16
);
   logic             out_valid;
   logic             out_ready;
   logic             out_last;
   logic [WIDTH-1:0] phase;

   modport master (
      output out_valid,
      output phase,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  phase,
      input  out_last,
      output out_ready
   );
endinterface

// File: rtl/chirp_phase_acc.sv
// LoRa chirp phase accumulator: phase += freq, freq += slope, one symbol of nsamp samples per start.
// Optional down-chirp support is built when CHIRP_PHASE_ACC_DOWN_EN is defined.
module chirp_phase_acc #(
   parameter int WIDTH = 16,
   parameter int MOD2X = 16384,
   parameter int FMAX  = 4096,
   parameter int CNT_W = 12
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic signed [WIDTH-1:0] freq0,
   input  logic signed [WIDTH-1:0] slope,
   input  logic [CNT_W-1:0]        nsamp,
   input  logic                    dir,
   output logic                    busy,
   chirp_phase_acc_if.master       out_if
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic signed [WIDTH:0] MOD2X_S    = (WIDTH+1)'(MOD2X);
   localparam logic signed [WIDTH:0] FMAX_S     = (WIDTH+1)'(FMAX);
   localparam logic signed [WIDTH:0] NEG_FMAX_S = -FMAX_S;
   localparam logic signed [WIDTH:0] FMAX2_S    = (WIDTH+1)'(2 * FMAX);

   state_t                  state_reg, state_next;
   logic signed [WIDTH-1:0] ph_reg, ph_next;
   logic signed [WIDTH-1:0] fr_reg, fr_next;
   logic signed [WIDTH-1:0] slp_reg, slp_next;
   logic [CNT_W-1:0]        cnt_reg, cnt_next;

   logic signed [WIDTH:0]   ph_sum, ph_wrap;
   logic signed [WIDTH:0]   fr_sum, fr_wrap;
   logic signed [WIDTH-1:0] slp_load;
   logic                    xfer;
   logic                    last;

   // Sums at WIDTH+1 bits never overflow; one correction step brings them back in range.
   always_comb begin
      ph_sum  = {ph_reg[WIDTH-1], ph_reg} + {fr_reg[WIDTH-1], fr_reg};
      ph_wrap = ph_sum;
      if (ph_sum[WIDTH]) begin
         ph_wrap = ph_sum + MOD2X_S;
      end else if (ph_sum >= MOD2X_S) begin
         ph_wrap = ph_sum - MOD2X_S;
      end

      fr_sum  = {fr_reg[WIDTH-1], fr_reg} + {slp_reg[WIDTH-1], slp_reg};
      fr_wrap = fr_sum;
      if (fr_sum >= FMAX_S) begin
         fr_wrap = fr_sum - FMAX2_S;
      end else if (fr_sum < NEG_FMAX_S) begin
         fr_wrap = fr_sum + FMAX2_S;
      end
   end

`ifdef CHIRP_PHASE_ACC_DOWN_EN
   // Negate at WIDTH+1 bits so that -(-FMAX) is representable before truncation.
   always_comb begin
      slp_load = slope;
      if (dir) begin
         slp_load = WIDTH'(-{slope[WIDTH-1], slope});
      end
   end
`else
   logic unused_dir;
   assign unused_dir = dir;
   assign slp_load   = slope;
`endif

   assign xfer = (state_reg == RUN) && out_if.out_ready;
   assign last = (cnt_reg == CNT_W'(1));

   always_comb begin
      state_next = state_reg;
      ph_next    = ph_reg;
      fr_next    = fr_reg;
      slp_next   = slp_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               fr_next    = freq0;
               slp_next   = slp_load;
               cnt_next   = nsamp;
               state_next = RUN;
            end
         end
         RUN: begin
            if (xfer) begin
               ph_next  = WIDTH'(ph_wrap);
               fr_next  = WIDTH'(fr_wrap);
               cnt_next = cnt_reg - CNT_W'(1);
               if (last) begin
                  // A start on the final transfer chains the next symbol with no bubble.
                  if (start) begin
                     fr_next  = freq0;
                     slp_next = slp_load;
                     cnt_next = nsamp;
                  end else begin
                     state_next = IDLE;
                  end
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         ph_reg    <= '0;
         fr_reg    <= '0;
         slp_reg   <= '0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         ph_reg    <= ph_next;
         fr_reg    <= fr_next;
         slp_reg   <= slp_next;
         cnt_reg   <= cnt_next;
      end
   end

   assign out_if.out_valid = (state_reg == RUN);
   assign out_if.phase     = ph_reg;
   assign out_if.out_last  = (state_reg == RUN) && last;
   assign busy             = (state_reg == RUN);

endmodule
